// File: rtl/logic_gate_pipe.sv
// Two-stage pipelined bitwise gate unit: eight selectable logic ops, result
// flags and popcount, valid/ready stream in and out, completed-beat counter.
module logic_gate_pipe #(
   parameter  int WIDTH = 8,
   parameter  int CNT_W = 16,
   localparam int POP_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_zero,
   output logic             y_ones,
   output logic [POP_W-1:0] y_pop,
   output logic [CNT_W-1:0] beat_cnt
);

   // Handshake: a beat moves on a rising edge where valid && ready are both 1.
   // ready never depends on valid of the same side; valid, once raised by the
   // unit, holds with stable data until the consumer takes it.

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOT  = 3'd2,
      OP_XOR  = 3'd3,
      OP_NAND = 3'd4,
      OP_NOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_y;
   logic [WIDTH-1:0] gate_y;
   logic             s1_adv;
   logic             s2_adv;
   logic             accept;
   logic             s1_zero;
   logic             s1_ones;
   logic [POP_W-1:0] s1_pop;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = rst_n && s1_adv;
   assign accept   = in_valid && in_ready;

   always_comb begin
      gate_y = '0;
      unique case (op_e'(op))
         OP_AND:  gate_y = a & b;
         OP_OR:   gate_y = a | b;
         OP_NOT:  gate_y = ~a;
         OP_XOR:  gate_y = a ^ b;
         OP_NAND: gate_y = ~(a & b);
         OP_NOR:  gate_y = ~(a | b);
         OP_XNOR: gate_y = ~(a ^ b);
         OP_PASS: gate_y = a;
      endcase
   end

   // Flags and popcount are derived from the S1 result so S2 only registers them.
   always_comb begin
      s1_pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         s1_pop = s1_pop + POP_W'(s1_y[i]);
      end
   end

   assign s1_zero = (s1_y == '0);
   assign s1_ones = &s1_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_y     <= '0;
      end else if (s1_adv) begin
         s1_valid <= accept;
         if (accept) begin
            s1_y <= gate_y;
         end
      end
   end

   // A bubble clears out_valid but leaves the last result registers untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         y         <= '0;
         y_zero    <= 1'b0;
         y_ones    <= 1'b0;
         y_pop     <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            y      <= s1_y;
            y_zero <= s1_zero;
            y_ones <= s1_ones;
            y_pop  <= s1_pop;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
      end else if (out_valid && out_ready) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomised and directed bench for logic_gate_pipe against a truth-table
// reference model; a CNT_W=4 twin shares the inputs to exercise counter wrap.
module tb_logic_gate_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [2:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] y;
   logic       y_zero;
   logic       y_ones;
   logic [3:0] y_pop;
   logic [15:0] beat_cnt;

   logic       w_in_ready;
   logic       w_out_valid;
   logic [7:0] w_y;
   logic       w_y_zero;
   logic       w_y_ones;
   logic [3:0] w_y_pop;
   logic [3:0] w_beat_cnt;

   logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .y_zero(y_zero), .y_ones(y_ones), .y_pop(y_pop), .beat_cnt(beat_cnt)
   );

   logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
      .a(a), .b(b), .op(op), .out_valid(w_out_valid), .out_ready(out_ready),
      .y(w_y), .y_zero(w_y_zero), .y_ones(w_y_ones), .y_pop(w_y_pop),
      .beat_cnt(w_beat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      int         cyc;
   } in_t;

   typedef struct {
      logic [7:0] y;
      logic       z;
      logic       o;
      logic [3:0] pop;
      int         cyc;
   } out_t;

   in_t        in_log[$];
   out_t       out_log[$];
   logic [7:0] exp_q[$];
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         exp_cnt = 0;

   // truth table per op, indexed by {a_bit, b_bit}
   logic [3:0] tt_tab [8] = '{4'b1000, 4'b1110, 4'b0011, 4'b0110,
                              4'b0111, 4'b0001, 4'b1001, 4'b1100};
   logic [7:0] y_tab  [8] = '{8'hC0, 8'hFC, 8'h0F, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0};
   logic [3:0] pop_tab[8] = '{4'd2, 4'd6, 4'd4, 4'd4, 4'd6, 4'd2, 4'd4, 4'd4};

   // Handshake recorder: logs what crossed each port; no checking here.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n) begin
         if (in_valid && in_ready) in_log.push_back('{op, a, b, cyc});
         if (out_valid && out_ready) out_log.push_back('{y, y_zero, y_ones, y_pop, cyc});
      end
   end

   function automatic logic [7:0] ref_y(input logic [2:0] o, input logic [7:0] x,
                                         input logic [7:0] z);
      logic [3:0] tt;
      logic [7:0] r;
      tt = tt_tab[o];
      for (int i = 0; i < 8; i++) r[i] = tt[{x[i], z[i]}];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (out_log.size() >= n) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (out_log.size() >= n) ok = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; a = 8'hF0; b = 8'h0F; op = 3'd1; out_ready = 1'b1;
      repeat (3) tick();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (y !== 8'h00) begin bad++; $display("FAIL reset_y: got %h want 00", y); end
      total++; if (beat_cnt !== 16'd0) begin bad++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); end
      total++; if ({y_zero, y_ones, y_pop} !== 6'd0) begin bad++; $display("FAIL reset_flags: got %b%b pop %0d want 0 0 0", y_zero, y_ones, y_pop); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
      exp_cnt = 0;
   endtask

   task automatic test_throughput();
      int bi, bo;
      bit ok;
      bi = in_log.size(); bo = out_log.size(); out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1; a = 8'hF0; b = 8'hCC; op = 3'(k);
         tick();
      end
      in_valid = 1'b0;
      wait_out(bo + 8, 20, ok);
      total++; if (!ok) begin bad++; $display("FAIL tp_timeout: got %0d outputs want 8", out_log.size() - bo); end
      total++; if (in_log.size() - bi != 8 || in_log[bi+7].cyc - in_log[bi].cyc != 7)
         begin bad++; $display("FAIL tp_accept: got %0d accepts want 8 back-to-back", in_log.size() - bi); end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (out_log[bo+k].y !== y_tab[k] || out_log[bo+k].pop !== pop_tab[k] ||
             out_log[bo+k].y !== ref_y(3'(k), 8'hF0, 8'hCC))
            begin bad++; $display("FAIL tp_op%0d: got y=%h pop=%0d want y=%h pop=%0d", k, out_log[bo+k].y, out_log[bo+k].pop, y_tab[k], pop_tab[k]); end
      end
      total++; if (out_log[bo].cyc - in_log[bi].cyc != 2) begin bad++; $display("FAIL tp_latency: got %0d want 2", out_log[bo].cyc - in_log[bi].cyc); end
      total++; if (out_log[bo+7].cyc - out_log[bo].cyc != 7) begin bad++; $display("FAIL tp_rate: got %0d cycles want 7", out_log[bo+7].cyc - out_log[bo].cyc); end
      exp_cnt += 8;
      total++; if (beat_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL tp_beat_cnt: got %0d want %0d", beat_cnt, exp_cnt); end
   endtask

   task automatic test_backpressure();
      logic [7:0] ba[5], bb[5], prev_y;
      logic [2:0] bo_op[5];
      int bi, bo, idx;
      bit saw_block, prev_stall;
      bi = in_log.size(); bo = out_log.size();
      saw_block = 1'b0; prev_stall = 1'b0; prev_y = '0;
      for (int i = 0; i < 5; i++) begin
         ba[i] = 8'($urandom); bb[i] = 8'($urandom); bo_op[i] = 3'($urandom_range(0, 7));
         exp_q.push_back(ref_y(bo_op[i], ba[i], bb[i]));
      end
      for (int c = 0; c < 40; c++) begin
         idx = in_log.size() - bi;
         if (idx < 5) begin in_valid = 1'b1; a = ba[idx]; b = bb[idx]; op = bo_op[idx]; end
         else in_valid = 1'b0;
         out_ready = !(c >= 2 && c < 6);
         #2;
         if (prev_stall) begin
            total++; if (y !== prev_y) begin bad++; $display("FAIL bp_hold: got y=%h want %h", y, prev_y); end
         end
         if (!in_ready && !saw_block) begin
            saw_block = 1'b1;
            total++; if (in_log.size() - out_log.size() != 2)
               begin bad++; $display("FAIL bp_inflight: got %0d want 2", in_log.size() - out_log.size()); end
         end
         prev_stall = out_valid && !out_ready;
         prev_y = y;
         if (out_log.size() - bo >= 5 && c > 10) break;
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      total++; if (!saw_block) begin bad++; $display("FAIL bp_block: got in_ready never 0 want 0 while full"); end
      total++; if (out_log.size() - bo != 5) begin bad++; $display("FAIL bp_count: got %0d want 5", out_log.size() - bo); end
      for (int i = 0; i < 5; i++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         total++; if (out_log[bo+i].y !== e) begin bad++; $display("FAIL bp_y%0d: got %h want %h", i, out_log[bo+i].y, e); end
      end
      exp_cnt += 5;
   endtask

   task automatic test_flags();
      logic [7:0] fa[3] = '{8'h00, 8'h00, 8'hA5};
      logic [7:0] fb[3] = '{8'h00, 8'h00, 8'hA5};
      logic [2:0] fo[3] = '{3'd0, 3'd4, 3'd3};
      logic [7:0] ey[3] = '{8'h00, 8'hFF, 8'h00};
      logic [2:0] ef[3] = '{3'b100, 3'b010, 3'b100};
      logic [3:0] ep[3] = '{4'd0, 4'd8, 4'd0};
      int bo;
      bit ok;
      bo = out_log.size(); out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = fa[i]; b = fb[i]; op = fo[i];
         tick();
      end
      in_valid = 1'b0;
      wait_out(bo + 3, 20, ok);
      total++; if (!ok) begin bad++; $display("FAIL flags_timeout: got %0d want 3", out_log.size() - bo); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (out_log[bo+i].y !== ey[i] || {out_log[bo+i].z, out_log[bo+i].o, 1'b0} !== ef[i] ||
             out_log[bo+i].pop !== ep[i])
            begin bad++; $display("FAIL flags%0d: got y=%h z=%b o=%b pop=%0d want y=%h zo=%b pop=%0d", i,
               out_log[bo+i].y, out_log[bo+i].z, out_log[bo+i].o, out_log[bo+i].pop, ey[i], ef[i][2:1], ep[i]); end
      end
      exp_cnt += 3;
   endtask

   task automatic test_random();
      localparam int N = 60;
      logic [7:0] ra[N], rb[N];
      logic [2:0] ro[N];
      int bi, bo, idx, errs;
      bit ok;
      bi = in_log.size(); bo = out_log.size(); errs = 0;
      for (int i = 0; i < N; i++) begin
         ra[i] = 8'($urandom); rb[i] = 8'($urandom); ro[i] = 3'($urandom_range(0, 7));
      end
      if (N > 4) begin ra[1] = 8'hFF; ro[1] = 3'd7; ra[2] = 8'h00; ro[2] = 3'd2; end
      for (int c = 0; c < 600 && in_log.size() - bi < N; c++) begin
         idx = in_log.size() - bi;
         out_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 3) != 0) begin in_valid = 1'b1; a = ra[idx]; b = rb[idx]; op = ro[idx]; end
         else begin in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      wait_out(bo + N, 20, ok);
      total++; if (!ok || out_log.size() - bo != N) begin bad++; $display("FAIL rnd_count: got %0d want %0d", out_log.size() - bo, N); end
      for (int i = 0; i < N; i++) begin
         logic [7:0] e;
         e = ref_y(ro[i], ra[i], rb[i]);
         if (out_log[bo+i].y !== e || out_log[bo+i].pop !== 4'($countones(e)) ||
             out_log[bo+i].z !== (e == 8'h00) || out_log[bo+i].o !== (e == 8'hFF)) begin
            errs++;
            if (errs < 5) $display("FAIL rnd_beat%0d: got y=%h pop=%0d want y=%h", i, out_log[bo+i].y, out_log[bo+i].pop, e);
         end
      end
      total++; if (errs != 0) begin bad++; $display("FAIL rnd_results: got %0d wrong beats want 0", errs); end
      exp_cnt += N;
      total++; if (beat_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL rnd_beat_cnt: got %0d want %0d", beat_cnt, exp_cnt); end
      total++; if (w_beat_cnt !== 4'(exp_cnt % 16)) begin bad++; $display("FAIL rnd_cnt4: got %0d want %0d", w_beat_cnt, exp_cnt % 16); end
   endtask

   task automatic test_mid_reset();
      int bo;
      out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         #2;
         if (!in_ready) break;
         tick();
      end
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL mr_full: got ov=%b ir=%b want 1 0", out_valid, in_ready); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || y !== 8'h00 || beat_cnt !== 16'd0 || in_ready !== 1'b0 || w_beat_cnt !== 4'd0)
         begin bad++; $display("FAIL mr_async: got ov=%b y=%h cnt=%0d ir=%b want 0 00 0 0", out_valid, y, beat_cnt, in_ready); end
      #1 rst_n = 1'b1;
      exp_cnt = 0;
      out_ready = 1'b1; bo = out_log.size();
      repeat (6) tick();
      total++; if (out_log.size() != bo || out_valid !== 1'b0) begin bad++; $display("FAIL mr_stale: got %0d beats want 0", out_log.size() - bo); end
   endtask

   task automatic test_wrap();
      int bo;
      bit ok;
      bo = out_log.size(); out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         exp_q.push_back(ref_y(op, a, b));
         tick();
      end
      in_valid = 1'b0;
      wait_out(bo + 17, 20, ok);
      total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got %0d want 17", out_log.size() - bo); end
      for (int i = 0; i < 17; i++) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         total++; if (out_log[bo+i].y !== e) begin bad++; $display("FAIL wrap_y%0d: got %h want %h", i, out_log[bo+i].y, e); end
      end
      exp_cnt += 17;
      total++; if (w_beat_cnt !== 4'd1) begin bad++; $display("FAIL wrap_cnt4: got %0d want 1", w_beat_cnt); end
      total++; if (beat_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL wrap_cnt16: got %0d want %0d", beat_cnt, exp_cnt); end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      test_reset();
      test_throughput();
      test_backpressure();
      test_flags();
      test_random();
      test_mid_reset();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
